// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction fetch unit
//
// Purpose: address/data widths, fetch FSM state encoding, prefetch entry
//          layout and the fetch-address increment helper.

package if_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;

  // Sequential fetch address; 8'hFF rolls over to 8'h00.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + 8'd1;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - prefetch FIFO of fetched {pc, data} entries
//
// Purpose: small power-of-two FIFO buffering fetched bytes with their
//          addresses. Flush has priority over push and pop.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   push       in   write push_data at the tail
//   push_data  in   entry to write
//   pop        in   drop the head entry
//   flush      in   empty the FIFO (wins over push/pop)
//   count      out  number of stored entries, 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
//   head       out  oldest stored entry

module if_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output fetch_entry_t               head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: memory read FSM + prefetch FIFO
//
// Purpose: issues single-outstanding byte reads starting at RESET_ADDR or a
//          redirect target, buffers fetched bytes in if_fifo and presents
//          them to the decoder over valid/ready. A redirect flushes the
//          FIFO; a read already in flight is completed and its data dropped.
// Optional: IF_BYPASS_EN - when the FIFO is empty, an acked byte is shown to
//           the decoder in the same cycle and is not stored if accepted.
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-low reset
//   redirect       in   one-cycle pulse: restart fetch at redirect_addr
//   redirect_addr  in   new fetch address
//   mem_req        out  read request, held until mem_ack
//   mem_addr       out  read address, stable while mem_req
//   mem_ack        in   read complete
//   mem_rdata      in   read data, valid with mem_ack
//   instr_valid    out  an instruction is presented
//   instr          out  instruction byte
//   instr_pc       out  address of instr
//   instr_ready    in   decoder accepts the presented instruction

module instr_fetch
  import if_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [7:0]  RESET_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       redirect,
  input  logic [7:0] redirect_addr,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic       instr_valid,
  output logic [7:0] instr,
  output logic [7:0] instr_pc,
  input  logic       instr_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state, state_nxt;
  logic [7:0]    fetch_addr, fetch_addr_nxt;
  logic [7:0]    drop_addr, drop_addr_nxt;
  fetch_entry_t  hold;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_flush;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_nxt;
  logic          fifo_full;
  logic          fifo_empty;
  fetch_entry_t  fifo_head;
  fetch_entry_t  fetched;

  logic          bypass_valid;
  logic          bypass_take;

  assign fetched = '{pc: fetch_addr, data: mem_rdata};

`ifdef IF_BYPASS_EN
  assign bypass_valid = fifo_empty && (state == REQ) && mem_ack && !redirect;
`else
  assign bypass_valid = 1'b0;
`endif
  assign bypass_take = bypass_valid && instr_ready;

  // Good data only arrives in REQ; in DROP the ack belongs to a stale address.
  assign fifo_push  = (state == REQ) && mem_ack && !redirect && !bypass_take;
  // A redirect flushes, so a pop in the same cycle is meaningless.
  assign fifo_pop   = !fifo_empty && instr_ready && !redirect;
  assign count_nxt  = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

  if_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fetched),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      fetch_addr <= RESET_ADDR;
      drop_addr  <= RESET_ADDR;
    end else begin
      state      <= state_nxt;
      fetch_addr <= fetch_addr_nxt;
      drop_addr  <= drop_addr_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    fetch_addr_nxt = fetch_addr;
    drop_addr_nxt  = drop_addr;
    fifo_flush     = 1'b0;
    case (state)
      IDLE: begin
        if (redirect) begin
          fifo_flush     = 1'b1;
          fetch_addr_nxt = redirect_addr;
          state_nxt      = REQ;
        end else if (!fifo_full) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          fifo_flush     = 1'b1;
          fetch_addr_nxt = redirect_addr;
          if (mem_ack) begin
            state_nxt = REQ;
          end else begin
            // Keep the in-flight address on the bus until its ack.
            drop_addr_nxt = fetch_addr;
            state_nxt     = DROP;
          end
        end else if (mem_ack) begin
          fetch_addr_nxt = next_addr(fetch_addr);
          // Only re-request with guaranteed room so an ack never overflows.
          state_nxt      = (count_nxt < CW'(DEPTH)) ? REQ : IDLE;
        end
      end
      DROP: begin
        if (redirect) begin
          fifo_flush     = 1'b1;
          fetch_addr_nxt = redirect_addr;
        end
        if (mem_ack) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_req  = (state != IDLE);
  assign mem_addr = (state == DROP) ? drop_addr : fetch_addr;

  // Last presented entry, so instr/instr_pc hold once the FIFO drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold <= '0;
    end else if (!fifo_empty) begin
      hold <= fifo_head;
    end else if (bypass_valid) begin
      hold <= fetched;
    end
  end

  assign instr_valid = !fifo_empty || bypass_valid;
  assign instr       = !fifo_empty ? fifo_head.data
                     : bypass_valid ? mem_rdata : hold.data;
  assign instr_pc    = !fifo_empty ? fifo_head.pc
                     : bypass_valid ? fetch_addr : hold.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch

module tb_instr_fetch;
  import if_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       redirect = 1'b0;
  logic [7:0] redirect_addr = 8'h00;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       instr_valid;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_ready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  int mem_delay = 0;
  int wcnt = 0;

  fetch_entry_t exp_q[$];
  logic [7:0]   addr_log[$];
  logic         forbid_en = 1'b0;
  logic [7:0]   forbid_pc = 8'h00;

  instr_fetch #(.DEPTH(4), .RESET_ADDR(8'h00)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
  );

  always #5 clk = ~clk;

  // Memory: data = addr ^ A5, ack after mem_delay extra cycles, one-cycle ack.
  initial forever begin
    @(negedge clk);
    if (!rst || !mem_req) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else if (wcnt >= mem_delay) begin
      mem_ack = 1'b1;
      mem_rdata = mem_addr ^ 8'hA5;
    end else begin
      wcnt++;
    end
  end

  // Monitor: logs acked addresses, checks accepted instructions vs scoreboard.
  initial forever begin
    fetch_entry_t e;
    @(negedge clk);
    #4;
    if (rst) begin
      if (mem_req && mem_ack) addr_log.push_back(mem_addr);
      if (forbid_en && instr_valid) begin
        n_cmp++;
        if (instr_pc === forbid_pc) begin
          n_bad++;
          $display("FAIL forbidden_pc: got instr_pc=%h, this address must never be output", instr_pc);
        end
      end
      if (instr_valid && instr_ready && !redirect && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (instr_pc !== e.pc) begin
          n_bad++;
          $display("FAIL sb_pc: got %h expected %h", instr_pc, e.pc);
        end
        n_cmp++;
        if (instr !== e.data) begin
          n_bad++;
          $display("FAIL sb_data: got %h expected %h (pc %h)", instr, e.data, e.pc);
        end
      end
    end
  end

  task automatic push_exp(input logic [7:0] pc);
    exp_q.push_back('{pc: pc, data: pc ^ 8'hA5});
  endtask

  task automatic apply_reset(input int delay, input logic ready);
    @(negedge clk);
    rst = 1'b0;
    redirect = 1'b0;
    instr_ready = ready;
    mem_delay = delay;
    repeat (2) @(negedge clk);
    exp_q.delete();
    addr_log.delete();
    forbid_en = 1'b0;
    rst = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 300 && exp_q.size() > 0; k++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d expected entries never output, required 0", name, exp_q.size());
    end
  endtask

  task automatic check_log(input string name, input int idx, input logic [7:0] want);
    n_cmp++;
    if (addr_log.size() <= idx) begin
      n_bad++;
      $display("FAIL %s: only %0d acks logged, required ack #%0d at %h", name, addr_log.size(), idx, want);
    end else if (addr_log[idx] !== want) begin
      n_bad++;
      $display("FAIL %s: ack #%0d addr %h required %h", name, idx, addr_log[idx], want);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b0;
    instr_ready = 1'b1;
    mem_delay = 0;
    #1;
    n_cmp++;
    if ({mem_req, mem_addr, instr_valid, instr, instr_pc} !== {1'b0, 8'h00, 1'b0, 8'h00, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_outputs: req=%b addr=%h valid=%b instr=%h pc=%h required 0/00/0/00/00",
               mem_req, mem_addr, instr_valid, instr, instr_pc);
    end
    repeat (2) @(negedge clk);
    exp_q.delete();
    addr_log.delete();
    push_exp(8'h00);
    push_exp(8'h01);
    push_exp(8'h02);
    rst = 1'b1;
    wait_drain("reset_seq");
    check_log("reset_addr0", 0, 8'h00);
    check_log("reset_addr1", 1, 8'h01);
    check_log("reset_addr2", 2, 8'h02);
  endtask

  task automatic test_backpressure;
    apply_reset(0, 1'b0);
    repeat (20) @(negedge clk);
    #2;
    n_cmp++;
    if (addr_log.size() != 4) begin
      n_bad++;
      $display("FAIL bp_ack_count: got %0d acks required 4", addr_log.size());
    end
    n_cmp++;
    if ({mem_req, instr_valid, instr_pc} !== {1'b0, 1'b1, 8'h00}) begin
      n_bad++;
      $display("FAIL bp_full_state: req=%b valid=%b pc=%h required 0/1/00", mem_req, instr_valid, instr_pc);
    end
    @(negedge clk);
    for (int i = 0; i < 5; i++) push_exp(8'(i));
    instr_ready = 1'b1;
    wait_drain("bp");
    check_log("bp_resume", 4, 8'h04);
  endtask

  task automatic test_redirect_midflight;
    bit held_ok = 1'b1;
    bit seen = 1'b0;
    apply_reset(3, 1'b1);
    forbid_en = 1'b1;
    forbid_pc = 8'h05;
    @(negedge clk);
    redirect = 1'b1;
    redirect_addr = 8'h05;
    @(negedge clk);
    redirect = 1'b0;
    #2;
    for (int k = 0; k < 20 && !(mem_req && mem_addr == 8'h05); k++) begin
      @(negedge clk);
      #2;
    end
    @(negedge clk);
    redirect = 1'b1;
    redirect_addr = 8'h40;
    push_exp(8'h40);
    push_exp(8'h41);
    @(negedge clk);
    redirect = 1'b0;
    #2;
    for (int k = 0; k < 20; k++) begin
      if (mem_req && mem_ack) begin
        seen = 1'b1;
        break;
      end
      if (mem_addr !== 8'h05 || mem_req !== 1'b1) held_ok = 1'b0;
      @(negedge clk);
      #2;
    end
    n_cmp++;
    if (!held_ok || !seen || mem_addr !== 8'h05) begin
      n_bad++;
      $display("FAIL mid_hold: held=%b ack_seen=%b ack_addr=%h required 1/1/05", held_ok, seen, mem_addr);
    end
    @(negedge clk);
    #2;
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 8'h40}) begin
      n_bad++;
      $display("FAIL mid_next_req: req=%b addr=%h required 1/40", mem_req, mem_addr);
    end
    wait_drain("mid");
  endtask

  task automatic test_redirect_on_ack;
    apply_reset(1, 1'b1);
    forbid_en = 1'b1;
    forbid_pc = 8'h10;
    @(negedge clk);
    redirect = 1'b1;
    redirect_addr = 8'h10;
    @(negedge clk);
    redirect = 1'b0;
    #2;
    for (int k = 0; k < 20; k++) begin
      if (mem_req && mem_ack && mem_addr == 8'h10) begin
        redirect = 1'b1;
        redirect_addr = 8'h80;
        push_exp(8'h80);
        push_exp(8'h81);
        break;
      end
      @(negedge clk);
      #2;
    end
    @(negedge clk);
    redirect = 1'b0;
    #2;
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 8'h80}) begin
      n_bad++;
      $display("FAIL ack_redir_next: req=%b addr=%h required 1/80", mem_req, mem_addr);
    end
    wait_drain("ack_redir");
  endtask

  task automatic test_wrap;
    apply_reset(0, 1'b1);
    @(negedge clk);
    redirect = 1'b1;
    redirect_addr = 8'hFE;
    push_exp(8'hFE);
    push_exp(8'hFF);
    push_exp(8'h00);
    push_exp(8'h01);
    @(negedge clk);
    redirect = 1'b0;
    wait_drain("wrap");
  endtask

  task automatic test_async_reset_drop;
    int ack_c = -1;
    int val_c = -1;
    int want_lat;
    apply_reset(3, 1'b1);
    @(negedge clk);
    redirect = 1'b1;
    redirect_addr = 8'h20;
    @(negedge clk);
    redirect = 1'b0;
    #2;
    for (int k = 0; k < 20 && !(mem_req && mem_addr == 8'h20); k++) begin
      @(negedge clk);
      #2;
    end
    @(negedge clk);
    redirect = 1'b1;
    redirect_addr = 8'h30;
    @(negedge clk);
    redirect = 1'b0;
    #2;
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 8'h20}) begin
      n_bad++;
      $display("FAIL drop_hold: req=%b addr=%h required 1/20", mem_req, mem_addr);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, instr_valid, mem_addr} !== {1'b0, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL async_reset: req=%b valid=%b addr=%h required 0/0/00", mem_req, instr_valid, mem_addr);
    end
    repeat (2) @(negedge clk);
    mem_delay = 0;
    exp_q.delete();
    addr_log.delete();
    push_exp(8'h00);
    push_exp(8'h01);
    rst = 1'b1;
    #2;
    for (int k = 0; k < 30; k++) begin
      if (ack_c < 0 && mem_req && mem_ack) ack_c = k;
      if (val_c < 0 && instr_valid) val_c = k;
      @(negedge clk);
      #2;
    end
`ifdef IF_BYPASS_EN
    want_lat = 0;
`else
    want_lat = 1;
`endif
    n_cmp++;
    if (ack_c < 0 || val_c - ack_c != want_lat) begin
      n_bad++;
      $display("FAIL ack_to_valid: ack cycle %0d valid cycle %0d required latency %0d", ack_c, val_c, want_lat);
    end
    wait_drain("post_reset");
    check_log("post_reset_addr", 0, 8'h00);
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect_midflight();
    test_redirect_on_ack();
    test_wrap();
    test_async_reset_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
